// File: rtl/vga_layer_compositor.sv
// vga_layer_compositor: priority/colour-key layer merge with blink, rgb and sync delayed through a common tick pipeline
module vga_layer_compositor #(
  parameter int               NUM_LAYERS   = 4,
  parameter int               RGB_W        = 8,
  parameter logic [RGB_W-1:0] KEY_RGB      = 8'hE3,
  parameter int               PIPE_STAGES  = 2,
  parameter int               BLINK_FRAMES = 30
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pixel_tick,
  input  logic                        video_on,
  input  logic                        hsync_in,
  input  logic                        vsync_in,
  input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0]       layer_en,
  input  logic [NUM_LAYERS-1:0]       blink_mask,
  input  logic [RGB_W-1:0]            bg_rgb,
  output logic [RGB_W-1:0]            rgb,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        blink_phase
);
  localparam int CW = $clog2(BLINK_FRAMES + 1);
  logic [PIPE_STAGES-1:0][RGB_W-1:0] pix_q, pix_d;
  logic [PIPE_STAGES-1:0]            hs_q, hs_d, vs_q, vs_d;
  logic [CW-1:0]                     cnt_q, cnt_d;
  logic                              phase_q, phase_d, vprev_q, vprev_d;
  logic [RGB_W-1:0]                  sel;
  logic                              fall, wrap;
  assign fall = vprev_q & ~vsync_in;
  assign wrap = cnt_q == CW'(BLINK_FRAMES - 1);
  // Walk from lowest priority up so the lowest-index opaque layer is written last
  always_comb begin
    sel = bg_rgb;
    for (int i = NUM_LAYERS - 1; i >= 0; i--)
      if (layer_en[i] && layer_rgb[i*RGB_W +: RGB_W] != KEY_RGB && !(blink_mask[i] && phase_q))
        sel = layer_rgb[i*RGB_W +: RGB_W];
  end
  always_comb begin
    pix_d   = pix_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    vprev_d = vprev_q;
    if (pixel_tick) begin
      pix_d[0] = video_on ? sel : '0;
      hs_d[0]  = hsync_in;
      vs_d[0]  = vsync_in;
      for (int s = 1; s < PIPE_STAGES; s++) begin
        pix_d[s] = pix_q[s-1];
        hs_d[s]  = hs_q[s-1];
        vs_d[s]  = vs_q[s-1];
      end
      vprev_d = vsync_in;
      if (fall) begin
        cnt_d   = wrap ? '0 : cnt_q + CW'(1);
        phase_d = phase_q ^ wrap;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_q   <= '0;
      hs_q    <= '1;
      vs_q    <= '1;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      vprev_q <= 1'b1;
    end else begin
      pix_q   <= pix_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      vprev_q <= vprev_d;
    end
  end
  assign rgb         = pix_q[PIPE_STAGES-1];
  assign hsync       = hs_q[PIPE_STAGES-1];
  assign vsync       = vs_q[PIPE_STAGES-1];
  assign blink_phase = phase_q;
endmodule
